// File: rtl/rle_decoder.sv
// Run-length decoder: expands {symbol,count} byte pairs read from DPSRAM port A into packed words written back.
// Optional RLE_CHECK_EN adds a sticky format-error flag (zero count, odd size, truncation).
module rle_decoder #(
  parameter int MAX_MSG_SIZE = 16384,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [31:0]       rle_addr,
  input  logic [31:0]       rle_size,
  input  logic [31:0]       message_addr,
  output logic [31:0]       message_size,
  output logic              done,
  output logic              error,
  output logic              port_A_clk,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, LATCH, EXPAND, WR, FLUSH, DONE
  } state_t;

  state_t              state_q, state_d;
  logic                start_q;
  logic [ADDR_W-1:0]   rle_base_q, rle_base_d, msg_base_q, msg_base_d;
  logic [31:0]         rle_size_q, rle_size_d, rd_off_q, rd_off_d;
  logic [31:0]         word_q, word_d, msize_q, msize_d;
  logic                pair_q, pair_d, pair1_vld_q, pair1_vld_d;
  logic [7:0]          sym_q, sym_d, run_q, run_d;
  logic [23:0]         asm_q, asm_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdat_q, wdat_d;
  logic                we_q, we_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   rd_sum, wr_addr;
  logic                more_words, at_limit;
  logic                unused_hi;

  assign rd_sum     = rle_base_q + rd_off_q[ADDR_W-1:0];
  assign wr_addr    = msg_base_q + {msize_q[ADDR_W-1:2], 2'b00};
  assign more_words = ({1'b0, rd_off_q} + 33'd2) <= {1'b0, rle_size_q};
  assign at_limit   = (msize_q == 32'(MAX_MSG_SIZE));
  assign unused_hi  = ^{rle_addr, message_addr};

  assign port_A_clk     = clk;
  assign port_A_addr    = addr_q;
  assign port_A_data_in = wdat_q;
  assign port_A_we      = we_q;
  assign message_size   = msize_q;
  assign done           = (state_q == DONE);
`ifdef RLE_CHECK_EN
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rle_base_d  = rle_base_q;
    msg_base_d  = msg_base_q;
    rle_size_d  = rle_size_q;
    rd_off_d    = rd_off_q;
    word_d      = word_q;
    msize_d     = msize_q;
    pair_d      = pair_q;
    pair1_vld_d = pair1_vld_q;
    sym_d       = sym_q;
    run_d       = run_q;
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    we_d        = 1'b0;
    err_d       = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start && !start_q) begin
          rle_base_d = rle_addr[ADDR_W-1:0];
          msg_base_d = message_addr[ADDR_W-1:0];
          rle_size_d = rle_size;
          rd_off_d   = 32'd0;
          msize_d    = 32'd0;
          asm_d      = 24'd0;
          cnt_d      = 2'd0;
          run_d      = 8'd0;
`ifdef RLE_CHECK_EN
          err_d      = rle_size[0];
`endif
          state_d    = (rle_size == 32'd0) ? DONE : RD_REQ;
        end
      end
      RD_REQ: begin
        addr_d  = {rd_sum[ADDR_W-1:2], 2'b00};
        state_d = RD_WAIT;
      end
      RD_WAIT: state_d = LATCH;
      LATCH: begin
        word_d      = port_A_data_out;
        sym_d       = port_A_data_out[7:0];
        run_d       = port_A_data_out[15:8];
        pair_d      = 1'b0;
        pair1_vld_d = ({1'b0, rd_off_q} + 33'd4) <= {1'b0, rle_size_q};
        rd_off_d    = rd_off_q + 32'd4;
`ifdef RLE_CHECK_EN
        if (port_A_data_out[15:8] == 8'd0) err_d = 1'b1;
`endif
        state_d     = EXPAND;
      end
      EXPAND: begin
        if (at_limit) begin
`ifdef RLE_CHECK_EN
          if (run_q != 8'd0 || (!pair_q && pair1_vld_q) || more_words) err_d = 1'b1;
`endif
          state_d = FLUSH;
        end else if (run_q == 8'd0) begin
          // Current pair exhausted (or count was zero): pick the next source of bytes.
          if (!pair_q && pair1_vld_q) begin
            pair_d = 1'b1;
            sym_d  = word_q[23:16];
            run_d  = word_q[31:24];
`ifdef RLE_CHECK_EN
            if (word_q[31:24] == 8'd0) err_d = 1'b1;
`endif
          end else if (more_words) begin
            state_d = RD_REQ;
          end else begin
            state_d = FLUSH;
          end
        end else begin
          run_d   = run_q - 8'd1;
          msize_d = msize_q + 32'd1;
          cnt_d   = cnt_q + 2'd1;
          case (cnt_q)
            2'd0: asm_d[7:0]   = sym_q;
            2'd1: asm_d[15:8]  = sym_q;
            2'd2: asm_d[23:16] = sym_q;
            default: begin
              addr_d  = wr_addr;
              wdat_d  = {sym_q, asm_q};
              we_d    = 1'b1;
              asm_d   = 24'd0;
              state_d = WR;
            end
          endcase
        end
      end
      WR: state_d = EXPAND;
      FLUSH: begin
        if (cnt_q != 2'd0) begin
          addr_d = wr_addr;
          wdat_d = {8'h00, asm_q};
          we_d   = 1'b1;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      rle_base_q  <= '0;
      msg_base_q  <= '0;
      rle_size_q  <= '0;
      rd_off_q    <= '0;
      word_q      <= '0;
      msize_q     <= '0;
      pair_q      <= 1'b0;
      pair1_vld_q <= 1'b0;
      sym_q       <= '0;
      run_q       <= '0;
      asm_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdat_q      <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      rle_base_q  <= rle_base_d;
      msg_base_q  <= msg_base_d;
      rle_size_q  <= rle_size_d;
      rd_off_q    <= rd_off_d;
      word_q      <= word_d;
      msize_q     <= msize_d;
      pair_q      <= pair_d;
      pair1_vld_q <= pair1_vld_d;
      sym_q       <= sym_d;
      run_q       <= run_d;
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      we_q        <= we_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_rle_decoder.sv
// Directed bench for rle_decoder with a word-addressed synchronous DPSRAM model.
module tb_rle_decoder;
  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] rle_addr = '0, rle_size = '0, message_addr = '0;
  logic [31:0] message_size;
  logic        done, error, port_A_clk, port_A_we;
  logic [31:0] port_A_data_in, port_A_data_out;
  logic [15:0] port_A_addr;

  logic [31:0] mem [0:16383];
  logic        poke_en = 1'b0;
  logic [13:0] poke_idx = '0;
  logic [31:0] poke_dat = '0;
  int          writes = 0;
  int          checks = 0;
  int          failures = 0;
  int          base_w;

`ifdef RLE_CHECK_EN
  localparam logic [31:0] EXP_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif

  rle_decoder #(.MAX_MSG_SIZE(16384), .ADDR_W(16)) dut (
    .clk(clk), .nreset(nreset), .start(start),
    .rle_addr(rle_addr), .rle_size(rle_size), .message_addr(message_addr),
    .message_size(message_size), .done(done), .error(error),
    .port_A_clk(port_A_clk), .port_A_data_in(port_A_data_in),
    .port_A_data_out(port_A_data_out), .port_A_addr(port_A_addr),
    .port_A_we(port_A_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_dat;
    else if (port_A_we) begin
      mem[port_A_addr[15:2]] <= port_A_data_in;
      writes <= writes + 1;
    end
    port_A_data_out <= mem[port_A_addr[15:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] dat);
    poke_en = 1'b1; poke_idx = 14'(idx); poke_dat = dat;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic decode(input logic [31:0] ra, input logic [31:0] rs, input logic [31:0] ma);
    rle_addr = ra; rle_size = rs; message_addr = ma;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
    end
    check(tag, {31'd0, done}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_size", message_size, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, error}, 32'd0);
    check("rst_we", {31'd0, port_A_we}, 32'd0);
    check("rst_addr", {16'd0, port_A_addr}, 32'd0);
    check("rst_din", port_A_data_in, 32'd0);
    nreset = 1'b1;

    // (0x41,3),(0x42,2) -> AAABB
    poke(50, 32'h02420341);
    decode(32'hC8, 32'd4, 32'h0);
    wait_done("t1_done", 100);
    check("t1_size", message_size, 32'd5);
    check("t1_w0", mem[0], 32'h42414141);
    check("t1_w1", mem[1], 32'h00000042);
    check("t1_err", {31'd0, error}, 32'd0);

    // six pairs, counts 5,7,12,4,10,10 -> 48 bytes
    poke(50, 32'h07620561);
    poke(51, 32'h04640C63);
    poke(52, 32'h0A660A65);
    decode(32'hC8, 32'd12, 32'h400);
    wait_done("t2_done", 400);
    check("t2_size", message_size, 32'd48);
    check("t2_w0", mem[256], 32'h61616161);
    check("t2_w1", mem[257], 32'h62626261);
    check("t2_w2", mem[258], 32'h62626262);
    check("t2_w3", mem[259], 32'h63636363);
    check("t2_w5", mem[261], 32'h63636363);
    check("t2_w6", mem[262], 32'h64646464);
    check("t2_w8", mem[264], 32'h65656565);
    check("t2_w9", mem[265], 32'h66666565);
    check("t2_w11", mem[267], 32'h66666666);

    // single 255-byte run
    poke(64, 32'h0000FF5A);
    poke(576, 32'hDEADBEEF);
    base_w = writes;
    decode(32'h100, 32'd2, 32'h800);
    wait_done("t3_done", 2000);
    check("t3_size", message_size, 32'd255);
    for (int i = 0; i < 63; i++) check("t3_word", mem[512 + i], 32'h5A5A5A5A);
    check("t3_tail", mem[575], 32'h005A5A5A);
    check("t3_beyond", mem[576], 32'hDEADBEEF);
    check("t3_writes", 32'(writes - base_w), 32'd64);

    // empty frame
    base_w = writes;
    decode(32'h100, 32'd0, 32'h900);
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_size", message_size, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_writes", 32'(writes - base_w), 32'd0);

    // reset in the middle of the 255-run expansion
    decode(32'h100, 32'd2, 32'hE00);
    repeat (40) @(posedge clk);
    #1;
    check("t5_busy", {31'd0, done}, 32'd0);
    nreset = 1'b0;
    @(posedge clk); #1;
    base_w = writes;
    check("t5_size", message_size, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_we", {31'd0, port_A_we}, 32'd0);
    check("t5_addr", {16'd0, port_A_addr}, 32'd0);
    check("t5_din", port_A_data_in, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    nreset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("t5_nowrite", 32'(writes - base_w), 32'd0);

    // restart after reset
    poke(50, 32'h02420341);
    decode(32'hC8, 32'd4, 32'hC00);
    wait_done("t6_done", 100);
    check("t6_size", message_size, 32'd5);
    check("t6_w0", mem[768], 32'h42414141);
    check("t6_w1", mem[769], 32'h00000042);

    // zero-count pair then (0x22,1)
    poke(192, 32'h01220011);
    decode(32'h300, 32'd4, 32'hA00);
    wait_done("t7_done", 100);
    check("t7_size", message_size, 32'd1);
    check("t7_err", {31'd0, error}, EXP_ERR);
    check("t7_w0", mem[640], 32'h00000022);

    // error clears on the next accepted start
    decode(32'h300, 32'd0, 32'hA00);
    check("t8_err", {31'd0, error}, 32'd0);

    // odd size: trailing lone byte ignored
    poke(193, 32'h00770241);
    decode(32'h304, 32'd3, 32'hB00);
    wait_done("t9_done", 100);
    check("t9_size", message_size, 32'd2);
    check("t9_err", {31'd0, error}, EXP_ERR);
    check("t9_w0", mem[704], 32'h00004141);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
